// File: rtl/lvds_rx9_align_ctrl_if.sv
// Control/status and deserializer-side bundle for the 9-lane x10 LVDS receive
// alignment controller. The controller takes the master modport.
interface lvds_rx9_align_ctrl_if #(
  parameter int NCH = 9,
  parameter int W   = 10
);
  logic              start;
  logic              i_rx_locked;
  logic [NCH*W-1:0]  i_rx_data;
  logic              o_pll_areset;
  logic [NCH-1:0]    o_rx_cda_reset;
  logic [NCH-1:0]    o_rx_cda;
  logic              o_cda_rdy;
  logic              o_busy;
  logic              o_fail;
  logic [NCH-1:0]    o_fail_mask;

  modport master (
    input  start, i_rx_locked, i_rx_data,
    output o_pll_areset, o_rx_cda_reset, o_rx_cda,
           o_cda_rdy, o_busy, o_fail, o_fail_mask
  );

  modport slave (
    output start, i_rx_locked, i_rx_data,
    input  o_pll_areset, o_rx_cda_reset, o_rx_cda,
           o_cda_rdy, o_busy, o_fail, o_fail_mask
  );
endinterface

// File: rtl/lvds_rx9_align_ctrl.sv
// PLL reset / lock / per-lane bit-slip training controller for a 9-lane x10 LVDS rx.
// Optional RX9_ALIGN_RETRY_EN: FAIL re-runs training up to 3 times before o_fail.
module lvds_rx9_align_ctrl #(
  parameter int             NCH          = 9,
  parameter int             W            = 10,
  parameter logic [W-1:0]   TRAIN        = 10'h3F0,
  parameter int             PLL_RST_CYC  = 16,
  parameter int             LOCK_TIMEOUT = 50000,
  parameter int             SETTLE_CYC   = 8,
  parameter int             MATCH_CNT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lvds_rx9_align_ctrl_if.master bus
);

  localparam int LW = $clog2(NCH);
  localparam int SW = $clog2(W + 1);
  localparam int MW = $clog2(MATCH_CNT + 1);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_PLL_RST   = 4'd1;
  localparam logic [3:0] ST_WAIT_LOCK = 4'd2;
  localparam logic [3:0] ST_CDA_RST   = 4'd3;
  localparam logic [3:0] ST_SETTLE    = 4'd4;
  localparam logic [3:0] ST_CHECK     = 4'd5;
  localparam logic [3:0] ST_SLIP      = 4'd6;
  localparam logic [3:0] ST_NEXT      = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;
  localparam logic [3:0] ST_FAIL      = 4'd9;

  localparam logic [LW-1:0] LAST_LANE = LW'(NCH - 1);

  logic [3:0]     state_q, state_d;
  logic [15:0]    timer_q, timer_d, timer_inc;
  logic [LW-1:0]  lane_q, lane_d;
  logic [SW-1:0]  slip_q, slip_d;
  logic [MW-1:0]  match_q, match_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic           lock_meta_q, lock_sync_q;
`ifdef RX9_ALIGN_RETRY_EN
  logic [1:0]     retry_q, retry_d;
`endif

  logic           pll_areset_q, pll_areset_d;
  logic [NCH-1:0] cda_reset_q, cda_reset_d;
  logic [NCH-1:0] rx_cda_q, rx_cda_d;
  logic           cda_rdy_q, cda_rdy_d;
  logic           busy_q, busy_d;
  logic           fail_q, fail_d;

  logic [W-1:0]   lane_word;
  logic           lock_lost;
  logic           lane_phase;

  assign lane_word  = bus.i_rx_data[lane_q*W +: W];
  assign lock_lost  = !lock_sync_q;
  assign timer_inc  = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
  assign lane_phase = (state_q == ST_SETTLE) || (state_q == ST_CHECK) ||
                      (state_q == ST_SLIP)   || (state_q == ST_NEXT)  ||
                      (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_inc;
    lane_d  = lane_q;
    slip_d  = slip_q;
    match_d = match_q;
    mask_d  = mask_q;
`ifdef RX9_ALIGN_RETRY_EN
    retry_d = retry_q;
`endif

    case (state_q)
      ST_IDLE: timer_d = '0;
      ST_PLL_RST: begin
        if (timer_q == 16'(PLL_RST_CYC - 1)) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync_q) begin
          state_d = ST_CDA_RST;
          timer_d = '0;
        end else if (timer_q == 16'(LOCK_TIMEOUT)) begin
          state_d = ST_FAIL;
          mask_d  = '1;
        end
      end
      ST_CDA_RST: begin
        if (timer_q == 16'd1) begin
          state_d = ST_SETTLE;
          timer_d = '0;
          lane_d  = '0;
          slip_d  = '0;
          match_d = '0;
        end
      end
      ST_SETTLE: begin
        if (timer_q == 16'(SETTLE_CYC - 1)) begin
          state_d = ST_CHECK;
          timer_d = '0;
        end
      end
      ST_CHECK: begin
        if (lane_word == TRAIN) begin
          if (match_q == MW'(MATCH_CNT - 1)) begin
            state_d = ST_NEXT;
            match_d = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end else begin
          match_d = '0;
          state_d = ST_SLIP;
        end
      end
      // A lane that has already been slipped through every bit position gives up.
      ST_SLIP: begin
        if (slip_q == SW'(W)) begin
          mask_d[lane_q] = 1'b1;
          state_d        = ST_NEXT;
        end else begin
          slip_d  = slip_q + SW'(1);
          state_d = ST_SETTLE;
          timer_d = '0;
        end
      end
      ST_NEXT: begin
        if (lane_q == LAST_LANE) begin
          if (mask_q == '0) begin
            state_d = ST_DONE;
`ifdef RX9_ALIGN_RETRY_EN
            retry_d = '0;
`endif
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          lane_d  = lane_q + LW'(1);
          slip_d  = '0;
          match_d = '0;
          state_d = ST_CHECK;
        end
      end
      ST_DONE: timer_d = '0;
      ST_FAIL: begin
        timer_d = '0;
`ifdef RX9_ALIGN_RETRY_EN
        if (retry_q != 2'd3) begin
          retry_d = retry_q + 2'd1;
          state_d = ST_PLL_RST;
          lane_d  = '0;
          slip_d  = '0;
          match_d = '0;
          mask_d  = '0;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // start overrides lock loss, so it is applied last.
    if (lane_phase && lock_lost) begin
      state_d = ST_PLL_RST;
      timer_d = '0;
      lane_d  = '0;
      slip_d  = '0;
      match_d = '0;
      mask_d  = '0;
    end
    if (bus.start) begin
      state_d = ST_PLL_RST;
      timer_d = '0;
      lane_d  = '0;
      slip_d  = '0;
      match_d = '0;
      mask_d  = '0;
`ifdef RX9_ALIGN_RETRY_EN
      retry_d = '0;
`endif
    end
  end

  // Outputs are decoded from the current state and registered, so they trail it by one cycle.
  always_comb begin
    pll_areset_d = (state_q == ST_PLL_RST);
    cda_reset_d  = {NCH{state_q == ST_CDA_RST}};
    rx_cda_d     = '0;
    if ((state_q == ST_SLIP) && (slip_q != SW'(W)))
      rx_cda_d[lane_q] = 1'b1;
    cda_rdy_d    = (state_q == ST_DONE);
    busy_d       = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL));
`ifdef RX9_ALIGN_RETRY_EN
    fail_d       = (state_q == ST_FAIL) && (retry_q == 2'd3);
`else
    fail_d       = (state_q == ST_FAIL);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      lane_q       <= '0;
      slip_q       <= '0;
      match_q      <= '0;
      mask_q       <= '0;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
`ifdef RX9_ALIGN_RETRY_EN
      retry_q      <= '0;
`endif
      pll_areset_q <= 1'b1;
      cda_reset_q  <= '1;
      rx_cda_q     <= '0;
      cda_rdy_q    <= 1'b0;
      busy_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lane_q       <= lane_d;
      slip_q       <= slip_d;
      match_q      <= match_d;
      mask_q       <= mask_d;
      lock_meta_q  <= bus.i_rx_locked;
      lock_sync_q  <= lock_meta_q;
`ifdef RX9_ALIGN_RETRY_EN
      retry_q      <= retry_d;
`endif
      pll_areset_q <= pll_areset_d;
      cda_reset_q  <= cda_reset_d;
      rx_cda_q     <= rx_cda_d;
      cda_rdy_q    <= cda_rdy_d;
      busy_q       <= busy_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.o_pll_areset   = pll_areset_q;
  assign bus.o_rx_cda_reset = cda_reset_q;
  assign bus.o_rx_cda       = rx_cda_q;
  assign bus.o_cda_rdy      = cda_rdy_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_fail         = fail_q;
  assign bus.o_fail_mask    = mask_q;

endmodule

// File: doc/lvds_rx9_align_ctrl.md
# lvds_rx9_align_ctrl

Power-up and training controller for the 9-lane, x10 LVDS receive datapath. It sequences the receiver PLL reset and waits for PLL lock. It then resets each channel's data-alignment logic and bit-slips each lane in turn until the lane's 10-bit word equals the training pattern. Its outputs drive the deserializer's `pll_areset`, `rx_cda_reset` and `rx_channel_data_align` inputs and the downstream `cda_rdy` qualifier.

## Interface
- `NCH`, 9: number of LVDS lanes.
- `W`, 10: deserialization factor (bits per lane word).
- `TRAIN`, 10'h3F0: training word expected on every lane.
- `PLL_RST_CYC`, 16: cycles `o_pll_areset` is held high.
- `LOCK_TIMEOUT`, 50000: cycles allowed for lock before failure.
- `SETTLE_CYC`, 8: cycles waited after any cda reset or slip before comparing.
- `MATCH_CNT`, 4: consecutive matching samples needed to declare a lane aligned.

Ports:
- `clk`  in  1  free-running system clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse; (re)starts training from any state.
- `i_rx_locked`  in  1  PLL lock, asynchronous; 2-flop synchronized internally.
- `i_rx_data`  in  NCH*W  deserialized words, lane n at [n*W+W-1:n*W], already in `clk` domain.
- `o_pll_areset`  out  1  PLL reset.
- `o_rx_cda_reset`  out  NCH  per-lane alignment reset.
- `o_rx_cda`  out  NCH  per-lane bit-slip pulse.
- `o_cda_rdy`  out  1  all lanes trained; datapath valid.
- `o_busy`  out  1  training in progress.
- `o_fail`  out  1  training ended with a failure.
- `o_fail_mask`  out  NCH  lanes that never matched `TRAIN`.

## Operation
- The controller uses these states: IDLE, PLL_RST, WAIT_LOCK, CDA_RST, SETTLE, CHECK, SLIP, NEXT, DONE, FAIL.
- IDLE: wait for `start`, then go to PLL_RST.
- PLL_RST: `o_pll_areset`=1 for `PLL_RST_CYC` cycles, then WAIT_LOCK.
- WAIT_LOCK: exit to CDA_RST on the synchronized lock. If the timer reaches `LOCK_TIMEOUT`, go to FAIL with `o_fail_mask` all ones.
- CDA_RST: `o_rx_cda_reset` is all ones for 2 cycles. Then lane index = 0, slip count = 0, and go to SETTLE.
- SETTLE: wait `SETTLE_CYC` cycles, then CHECK.
- CHECK:
  - A lane word equal to `TRAIN` increments the match counter. Reaching `MATCH_CNT` goes to NEXT.
  - Any mismatch clears the match counter and goes to SLIP.
- SLIP: `o_rx_cda[lane]`=1 for exactly 1 cycle and slip count increments, then SETTLE.
  - If slip count already equals `W` before the slip, do not slip. Set `o_fail_mask[lane]` and go to NEXT.
- NEXT:
  - lane==NCH-1: go to DONE if the mask is zero, otherwise FAIL.
  - Otherwise: lane+1, slip count = 0, match counter = 0, then CHECK.
- DONE: `o_cda_rdy`=1. Loss of synchronized lock clears `o_cda_rdy` and goes to PLL_RST.
- In SETTLE/CHECK/SLIP/NEXT, loss of lock also goes to PLL_RST. It clears `o_fail_mask` and the lane state.
- `start` in any state restarts at PLL_RST with all lane state cleared. `start` takes priority over a simultaneous lock loss.
- `o_busy`=1 in every state except IDLE, DONE and FAIL.

## Timing
- All outputs are registered.
- Reset values: `o_pll_areset`=1, `o_rx_cda_reset`=all ones, `o_rx_cda`=0, `o_cda_rdy`=0, `o_busy`=0, `o_fail`=0, `o_fail_mask`=0. State is IDLE.
- At the first edge after reset release, `o_pll_areset` and `o_rx_cda_reset` drop to 0.
- `start` is sampled on an edge. `o_pll_areset` rises on the next edge.
- The lock synchronizer adds 2 cycles.
- At most one bit of `o_rx_cda` is high in any cycle. Consecutive slip pulses on a lane are separated by at least `SETTLE_CYC`+1 cycles.
- Per-lane best case is `SETTLE_CYC`+`MATCH_CNT` cycles after CDA_RST, for lane 0 only.
- Timers are 16 bits and saturate; they never wrap.
- Reset mid-training aborts immediately and returns to the reset values.

## Configuration
- `RX9_ALIGN_RETRY_EN` defined:
  - FAIL automatically re-enters PLL_RST up to 3 times, counted by a 2-bit retry counter.
  - `o_fail` asserts only after the 3rd retry fails.
  - The retry counter clears on `start` or on reaching DONE.
- Not defined: FAIL is sticky until `start` or reset; `o_fail` asserts on entry to FAIL.

## Test plan
- Reset, `start`, lock 100 cycles later, all lanes already showing 10'h3F0 → zero `o_rx_cda` pulses. `o_cda_rdy`=1 and `o_fail_mask`=0.
- Lane 3 word is rotated 4 bits and a bench model rotates it by one per slip → exactly 4 `o_rx_cda[3]` pulses, then DONE.
- Lane 7 stuck at 10'h000 → 10 slips on lane 7, `o_fail_mask`=9'h080, `o_fail`=1 (macro undefined).
- Lock never asserts → FAIL at 16+50000+2 cycles after start, mask 9'h1FF. With `RX9_ALIGN_RETRY_EN`, 4 PLL_RST entries occur before `o_fail`.
- Lock drops during lane 5 CHECK → `o_pll_areset` pulse and mask cleared. Training reruns and reaches DONE after lock returns.
- `start` and lock loss in the same cycle while in DONE → single restart to PLL_RST with `o_cda_rdy`=0 on the next edge.
